// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: pops the FIFO, absorbs read latency in a 2-entry buffer.
// Optional FIFO_RD_CTRL_STATS_EN adds a saturating words_out transfer counter.
module fifo_read_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_read_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef FIFO_RD_CTRL_STATS_EN
    ,
    output logic [15:0]      words_out
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       r_occ;
    logic [1:0]       w_occ_nxt;
    logic             r_inflight;
    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;
    logic             w_pop;
    logic             w_append;
    logic             w_slot1;
    logic [2:0]       w_commit;

    assign out_valid = (r_occ != EMPTY);
    assign out_data  = r_buf0;
    assign occupancy = r_occ;

    assign w_pop    = out_valid && out_ready;
    assign w_append = r_inflight && !flush;

    // Words held plus words owed, after this cycle's pop leaves.
    assign w_commit = {1'b0, r_occ} + {2'b00, r_inflight}
                    - {2'b00, w_pop};

    assign fifo_read_en = !fifo_empty && !flush && (w_commit < 3'd2);

    // Append lands behind the head once any pop has shifted it.
    assign w_slot1 = (r_occ == TWO) || ((r_occ == ONE) && !w_pop);

    always_comb begin
        w_occ_nxt = r_occ;
        if (flush) begin
            w_occ_nxt = EMPTY;
        end else begin
            case (r_occ)
                EMPTY: begin
                    if (w_append)
                        w_occ_nxt = ONE;
                end
                ONE: begin
                    if (w_append && !w_pop)
                        w_occ_nxt = TWO;
                    else if (!w_append && w_pop)
                        w_occ_nxt = EMPTY;
                end
                TWO: begin
                    if (w_pop)
                        w_occ_nxt = ONE;
                end
                default: w_occ_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= EMPTY;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= fifo_read_en;
            if (!flush) begin
                if (w_pop)
                    r_buf0 <= r_buf1;
                if (w_append) begin
                    if (w_slot1)
                        r_buf1 <= fifo_rd_data;
                    else
                        r_buf0 <= fifo_rd_data;
                end
            end
        end
    end

`ifdef FIFO_RD_CTRL_STATS_EN
    logic [15:0] r_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_words <= '0;
        else if (w_pop && (r_words != 16'hFFFF))
            r_words <= r_words + 16'd1;
    end

    assign words_out = r_words;
`endif

    // The buffer can never be overcommitted, nor outgrow the FIFO feeding it.
    a_no_overfill : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_append && (r_occ == TWO)));

    a_occ_range : assert property (@(posedge clk) disable iff (!rst_n)
        (int'(r_occ) <= DEPTH) && (r_occ != 2'd3));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural FIFO model on the read side.
// Checks latency, backpressure, ordering, flush and asynchronous reset.
module tb_fifo_read_ctrl;

    logic       clk;
    logic       rst_n;
    logic       fifo_empty;
    logic       fifo_read_en;
    logic [7:0] fifo_rd_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;
`ifdef FIFO_RD_CTRL_STATS_EN
    logic [15:0] words_out;
`endif

    int n_chk;
    int n_pass;
    int n_rd;
    int wp;
    int rp;
    logic [7:0] mem [0:63];
    logic [7:0] rx [$];

    fifo_read_ctrl #(
        .DEPTH(8),
        .WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_empty  (fifo_empty),
        .fifo_read_en(fifo_read_en),
        .fifo_rd_data(fifo_rd_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy)
`ifdef FIFO_RD_CTRL_STATS_EN
        ,
        .words_out   (words_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO storage model: one-cycle read latency, reset with the controller.
    assign fifo_empty = (wp == rp);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp           <= 0;
            fifo_rd_data <= 8'h00;
        end else if (fifo_read_en) begin
            fifo_rd_data <= mem[rp[5:0]];
            rp           <= rp + 1;
        end
    end

    // Sink side: record every transfer and every pop request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready)
                rx.push_back(out_data);
            if (fifo_read_en)
                n_rd = n_rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass = n_pass + 1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp[5:0]] = d;
        wp = wp + 1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++)
            @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_a [0:4];
        n_chk     = 0;
        n_pass    = 0;
        n_rd      = 0;
        wp        = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rden", fifo_read_en, 0);

        // Latency and back-to-back delivery
        push(8'h11);
        push(8'h22);
        push(8'h33);
        out_ready = 1'b1;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("lat_rden_t0", fifo_read_en, 1);
        chk("lat_valid_t0", out_valid, 0);
        @(negedge clk);
        chk("lat_valid_t1", out_valid, 0);
        @(negedge clk);
        chk("lat_valid_t2", out_valid, 1);
        chk("lat_data_t2", out_data, 8'h11);
        @(negedge clk);
        chk("lat_data_t3", out_data, 8'h22);
        @(negedge clk);
        chk("lat_data_t4", out_data, 8'h33);
        chk("lat_valid_t4", out_valid, 1);
        @(negedge clk);
        chk("lat_valid_t5", out_valid, 0);

        // Backpressure: stall for 6 cycles with 5 words queued
        tick;
        rx.delete();
        n_rd = 0;
        out_ready = 1'b0;
        exp_a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 5; i++)
            push(exp_a[i]);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2)
                chk($sformatf("stall_data_%0d", i), out_data, 8'hA1);
        end
        chk("stall_pops", n_rd, 2);
        chk("stall_occ", occupancy, 2);
        chk("stall_valid", out_valid, 1);
        tick;
        out_ready = 1'b1;
        @(negedge clk);
        chk("restart_rden", fifo_read_en, 1);
        wait_neg(20);
        chk("bp_count", rx.size(), 5);
        for (int i = 0; i < rx.size() && i < 5; i++)
            chk($sformatf("bp_word_%0d", i), rx[i], exp_a[i]);

        // Toggling ready against a continuous supply
        tick;
        rx.delete();
        for (int i = 1; i <= 8; i++)
            push(8'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        wait_neg(10);
        chk("tog_count", rx.size(), 8);
        for (int i = 0; i < rx.size() && i < 8; i++)
            chk($sformatf("tog_word_%0d", i), rx[i], i + 1);

        // Flush with a full buffer
        tick;
        rx.delete();
        out_ready = 1'b0;
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        push(8'hB4);
        wait_neg(4);
        chk("flA_occ_pre", occupancy, 2);
        tick;
        flush = 1'b1;
        @(negedge clk);
        chk("flA_rden", fifo_read_en, 0);
        tick;
        flush = 1'b0;
        @(negedge clk);
        chk("flA_valid", out_valid, 0);
        chk("flA_occ", occupancy, 0);
        tick;
        out_ready = 1'b1;
        wait_neg(10);
        chk("flA_count", rx.size(), 2);
        if (rx.size() == 2) begin
            chk("flA_word_0", rx[0], 8'hB3);
            chk("flA_word_1", rx[1], 8'hB4);
        end

        // Flush with a word in flight and a pop in the flush cycle
        tick;
        rx.delete();
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        push(8'hC4);
        tick;
        tick;
        tick;
        flush = 1'b1;
        @(negedge clk);
        chk("flB_head", out_data, 8'hC2);
        chk("flB_occ", occupancy, 1);
        chk("flB_rden", fifo_read_en, 0);
        tick;
        flush = 1'b0;
        @(negedge clk);
        chk("flB_valid", out_valid, 0);
        wait_neg(10);
        chk("flB_count", rx.size(), 3);
        if (rx.size() == 3) begin
            chk("flB_word_0", rx[0], 8'hC1);
            chk("flB_word_1", rx[1], 8'hC2);
            chk("flB_word_2", rx[2], 8'hC4);
        end
`ifdef FIFO_RD_CTRL_STATS_EN
        chk("stats_words", words_out, 21);
`endif

        // Asynchronous reset mid-stream
        tick;
        rx.delete();
        push(8'hD1);
        push(8'hD2);
        push(8'hD3);
        wait_neg(3);
        chk("ar_occ_pre", occupancy, 1);
        #2;
        rst_n = 1'b0;
        wp = 0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_rden", fifo_read_en, 0);
`ifdef FIFO_RD_CTRL_STATS_EN
        chk("ar_words", words_out, 0);
`endif
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_idle_valid", out_valid, 0);
        wait_neg(3);
        chk("ar_idle_occ", occupancy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
